// File: rtl/gauss_pkg.sv
// Shared types and constants for the Gaussian-elimination engine.
package gauss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int RD_LAT       = 1;

    // Row-major element address for a dim x dim matrix.
    function automatic int unsigned idx2addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/gauss_row_alu.sv
// Two-stage multiply-subtract A[i][k] - c[j]*A[j][k] with issue-address delay line.
// GAUSS_SAT_EN selects full-width arithmetic with saturation; otherwise results wrap.
module gauss_row_alu
    import gauss_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              issue_vld,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] ai,
    input  logic [DATA_W-1:0] aj,
    input  logic [DATA_W-1:0] c,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic [RD_LAT-1:0] vld_dly;
    logic [ADDR_W-1:0] addr_dly [RD_LAT];
    logic [DATA_W-1:0] result;

`ifdef GAUSS_SAT_EN
    logic [2*DATA_W-1:0] prod_full;
    logic [2*DATA_W:0]   diff_full;
    logic                ovf;

    // Overflow when the bits above the result sign are not a pure sign extension.
    always_comb begin
        prod_full = {{DATA_W{c[DATA_W-1]}}, c} * {{DATA_W{aj[DATA_W-1]}}, aj};
        diff_full = {{(DATA_W+1){ai[DATA_W-1]}}, ai} - {prod_full[2*DATA_W-1], prod_full};
        ovf       = (diff_full[2*DATA_W:DATA_W-1] != '0) &&
                    (diff_full[2*DATA_W:DATA_W-1] != '1);
        if (ovf) begin
            result = diff_full[2*DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = diff_full[DATA_W-1:0];
        end
    end
`else
    logic [DATA_W-1:0] prod;

    always_comb begin
        prod   = c * aj;
        result = ai - prod;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_dly <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                addr_dly[s] <= '0;
            end
        end else if (en) begin
            vld_dly[0]  <= issue_vld;
            addr_dly[0] <= issue_addr;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_dly[s]  <= vld_dly[s-1];
                addr_dly[s] <= addr_dly[s-1];
            end
        end
    end

    // Address/data only move on valid results so the write port stays quiet between passes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (en) begin
            wr_en <= vld_dly[RD_LAT-1];
            if (vld_dly[RD_LAT-1]) begin
                wr_addr <= addr_dly[RD_LAT-1];
                wr_data <= result;
            end
        end
    end

endmodule

// File: rtl/gauss_elim_engine.sv
// Sequential Gaussian-elimination engine: runs the j/i/k loop nest over A using c.
// Arithmetic mode (wrap vs. GAUSS_SAT_EN saturation) lives in gauss_row_alu.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one read triple issued per enabled cycle
// DRAIN | let the last writes of pass j land before pass j+1 reads
// FIN   | one-cycle done pulse
module gauss_elim_engine
    import gauss_pkg::*;
#(
    parameter  int N      = 16,
    parameter  int DATA_W = 32,
    localparam int ADDR_W = $clog2(N*N),
    localparam int IDX_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] a_rdi_addr,
    input  logic [DATA_W-1:0] a_rdi_data,
    output logic [ADDR_W-1:0] a_rdj_addr,
    input  logic [DATA_W-1:0] a_rdj_data,
    output logic [IDX_W-1:0]  c_rd_addr,
    input  logic [DATA_W-1:0] c_rd_data,
    output logic              a_wr_en,
    output logic [ADDR_W-1:0] a_wr_addr,
    output logic [DATA_W-1:0] a_wr_data,
    output logic [IDX_W-1:0]  cur_j
);

    localparam int               DRAIN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] J_LAST   = IDX_W'(N - 2);

    state_t             state;
    logic [IDX_W-1:0]   j_idx;
    logic [IDX_W-1:0]   i_idx;
    logic [IDX_W-1:0]   k_idx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               issue_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            j_idx     <= '0;
            i_idx     <= '0;
            k_idx     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        j_idx <= IDX_W'(1);
                        i_idx <= IDX_W'(2);
                        k_idx <= IDX_W'(1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (k_idx == IDX_LAST) begin
                        k_idx <= IDX_W'(1);
                        if (i_idx == IDX_LAST) begin
                            drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                            state     <= DRAIN;
                        end else begin
                            i_idx <= i_idx + IDX_W'(1);
                        end
                    end else begin
                        k_idx <= k_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (j_idx < J_LAST) begin
                            j_idx <= j_idx + IDX_W'(1);
                            i_idx <= j_idx + IDX_W'(2);
                            state <= RUN;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign issue_vld  = (state == RUN);
    assign a_rdi_addr = ADDR_W'(idx2addr(32'(i_idx), 32'(k_idx), N));
    assign a_rdj_addr = ADDR_W'(idx2addr(32'(j_idx), 32'(k_idx), N));
    assign c_rd_addr  = j_idx;
    assign cur_j      = j_idx;

    gauss_row_alu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_alu (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .issue_vld  (issue_vld),
        .issue_addr (a_rdi_addr),
        .ai         (a_rdi_data),
        .aj         (a_rdj_data),
        .c          (c_rd_data),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data)
    );

endmodule
